audio_sfx_scheduler: RTL

- Sequences sample playback for up to 4 sound channels (BGM plus effects) from one shared sample-memory read port.
- Commands arrive as a 32-bit word from the CPU-driven audio PIO output.
- On every codec sample tick, fetches one sample per active channel and sums them with saturation.
- Presents one 16-bit mixed sample to the codec serializer.

---
 rtl/audio_pkg.sv | 37 +++
 rtl/audio_sfx_channel.sv | 57 +++++
 rtl/audio_sfx_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants, command layout and FSM encoding for the audio sample-effect scheduler.
package audio_pkg;

  localparam int NCH       = 4;
  localparam int BLK_SHIFT = 8;

  localparam int CMD_TOGGLE   = 31;
  localparam int CMD_STOP     = 30;
  localparam int CMD_CH_LSB   = 28;
  localparam int CMD_LOOP     = 27;
  localparam int CMD_RSVD     = 26;
  localparam int CMD_BASE_LSB = 8;
  localparam int CMD_LEN_LSB  = 0;

  localparam int CH_W   = 2;
  localparam int BASE_W = 18;
  localparam int LEN_W  = 8;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic              stop;
    logic [CH_W-1:0]   ch;
    logic              loop;
    logic [BASE_W-1:0] base;
    logic [LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/audio_sfx_channel.sv
// One playback channel: command load/stop, sample address generation and
// end-of-sample wrap or stop.
module audio_sfx_channel #(
  parameter int ADDR_W    = 18,
  parameter int BLK_SHIFT = audio_pkg::BLK_SHIFT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic                       stop,
  input  logic [ADDR_W-1:0]          base_in,
  input  logic [audio_pkg::LEN_W-1:0] len_in,
  input  logic                       loop_in,
  input  logic                       advance,
  output logic [ADDR_W-1:0]          addr,
  output logic                       active
);
  import audio_pkg::*;

  localparam int POS_W = LEN_W + BLK_SHIFT;

  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic              loop_en;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  last_pos;

  // len is never 0 while active, so the subtraction cannot underflow in use
  assign last_pos = {len, {BLK_SHIFT{1'b0}}} - POS_W'(1);
  assign addr     = base + ADDR_W'(pos);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base    <= '0;
      len     <= '0;
      loop_en <= 1'b0;
      pos     <= '0;
      active  <= 1'b0;
    end else if (stop) begin
      active <= 1'b0;
    end else if (load) begin
      base    <= base_in;
      len     <= len_in;
      loop_en <= loop_in;
      pos     <= '0;
      active  <= 1'b1;
    end else if (advance) begin
      if (pos == last_pos) begin
        pos <= '0;
        if (!loop_en) active <= 1'b0;
      end else begin
        pos <= pos + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Per-tick sample fetch for up to four channels over one shared memory port,
// with saturating mix and a single-slot toggle-handshake command interface.
module audio_sfx_scheduler #(
  parameter int NCH       = audio_pkg::NCH,
  parameter int ADDR_W    = 18,
  parameter int BLK_SHIFT = audio_pkg::BLK_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cmd_word,
  input  logic                     sample_tick,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic signed [15:0]       mem_rdata,
  output logic signed [15:0]       mix_sample,
  output logic                     mix_valid,
  output logic [NCH-1:0]           ch_active,
  output logic                     overrun
);
  import audio_pkg::*;

  state_t             state, state_nxt;
  logic [CH_W-1:0]    ch_idx;
  logic signed [17:0] acc;
  logic signed [15:0] mix_hold;
  cmd_t               cmd_hold;
  logic               last_toggle, pending, apply;
  logic               cur_active, idx_last, ack_now;
  logic [ADDR_W-1:0]  ch_addr [NCH];
  logic               cmd_reserved_unused;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] a);
    if (a > 18'(SAT_MAX)) return SAT_MAX;
    if (a < 18'(SAT_MIN)) return SAT_MIN;
    return a[15:0];
  endfunction

  assign cmd_reserved_unused = cmd_word[CMD_RSVD];
  assign apply      = pending && (state == ST_IDLE) && !sample_tick;
  assign cur_active = ch_active[ch_idx];
  assign idx_last   = (ch_idx == CH_W'(NCH - 1));
  assign ack_now    = (state == ST_REQ) && mem_ack;

  // The newest toggle always replaces the held command; it is only consumed in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_toggle <= 1'b0;
      pending     <= 1'b0;
      cmd_hold    <= '0;
    end else if (cmd_word[CMD_TOGGLE] != last_toggle) begin
      last_toggle <= cmd_word[CMD_TOGGLE];
      pending     <= 1'b1;
      cmd_hold    <= '{stop: cmd_word[CMD_STOP],
                       ch:   cmd_word[CMD_CH_LSB +: CH_W],
                       loop: cmd_word[CMD_LOOP],
                       base: cmd_word[CMD_BASE_LSB +: BASE_W],
                       len:  cmd_word[CMD_LEN_LSB +: LEN_W]};
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    audio_sfx_channel #(.ADDR_W(ADDR_W), .BLK_SHIFT(BLK_SHIFT)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (apply && !cmd_hold.stop && (cmd_hold.len != '0) && (cmd_hold.ch == CH_W'(i))),
      .stop    (apply && cmd_hold.stop && (cmd_hold.ch == CH_W'(i))),
      .base_in (ADDR_W'(cmd_hold.base)),
      .len_in  (cmd_hold.len),
      .loop_in (cmd_hold.loop),
      .advance (ack_now && (ch_idx == CH_W'(i))),
      .addr    (ch_addr[i]),
      .active  (ch_active[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sample_tick) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (cur_active)    state_nxt = ST_REQ;
        else if (idx_last) state_nxt = ST_OUT;
      end
      ST_REQ:  if (mem_ack) state_nxt = idx_last ? ST_OUT : ST_SCAN;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      ch_idx   <= '0;
      mix_hold <= '0;
      overrun  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && sample_tick) begin
        acc    <= '0;
        ch_idx <= '0;
      end else if ((state == ST_SCAN) && !cur_active && !idx_last) begin
        ch_idx <= ch_idx + CH_W'(1);
      end else if (ack_now) begin
        acc <= acc + 18'(mem_rdata);
        if (!idx_last) ch_idx <= ch_idx + CH_W'(1);
      end
      if (state == ST_OUT) mix_hold <= sat16(acc);
      if (sample_tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mix_valid  = 1'b0;
    mix_sample = mix_hold;
    case (state)
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ch_addr[ch_idx];
      end
      ST_OUT: begin
        mix_valid  = 1'b1;
        mix_sample = sat16(acc);
      end
      default: ;
    endcase
  end

endmodule
